// File: rtl/hall_motor_emulator.sv
// Emulates a sensored BLDC rotor: decodes gate drive, models speed as clocks-per-sector and
// produces the matching Hall sensor outputs with a sticky shoot-through fault flag.
module hall_motor_emulator #(
    parameter int unsigned MAX_PERIOD = 64,
    parameter int unsigned MIN_PERIOD = 16,
    parameter int unsigned ACCEL      = 8,
    parameter int unsigned DECEL      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] MC,
    output logic [2:0] HS,
    output logic [2:0] sector,
    output logic       moving,
    output logic       dir,
    output logic       step,
    output logic       fault
);
    // One spare bit so period + 4*DECEL never wraps before saturation.
    localparam int unsigned PW = $clog2(MAX_PERIOD + 4 * DECEL) + 1;

    localparam logic [PW-1:0] LP_MAX     = PW'(MAX_PERIOD);
    localparam logic [PW-1:0] LP_MIN     = PW'(MIN_PERIOD);
    localparam logic [PW-1:0] LP_ACCEL   = PW'(ACCEL);
    localparam logic [PW-1:0] LP_MIN_ACC = PW'(MIN_PERIOD + ACCEL);
    localparam logic [PW-1:0] LP_DEC     = PW'(DECEL);
    localparam logic [PW-1:0] LP_DEC4    = PW'(4 * DECEL);
    localparam logic [PW-1:0] LP_ONE     = PW'(1);

    typedef enum logic [2:0] {ClsCoast, ClsBrake, ClsDriveCcw, ClsDriveCw, ClsFault} cls_e;

    function automatic logic [5:0] f_ccw_pat(input logic [2:0] s);
        case (s)
            3'd1:    return 6'b100100;
            3'd2:    return 6'b100001;
            3'd3:    return 6'b001001;
            3'd4:    return 6'b011000;
            3'd5:    return 6'b010010;
            3'd6:    return 6'b000110;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [2:0] f_hs(input logic [2:0] s);
        case (s)
            3'd1:    return 3'b100;
            3'd2:    return 3'b110;
            3'd3:    return 3'b010;
            3'd4:    return 3'b011;
            3'd5:    return 3'b001;
            3'd6:    return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] f_next(input logic [2:0] s, input logic d);
        if (d) return (s == 3'd6) ? 3'd1 : s + 3'd1;
        return (s == 3'd1) ? 3'd6 : s - 3'd1;
    endfunction

    logic [2:0]    r_sector, w_sector_nxt;
    logic [2:0]    r_hs, w_hs_nxt;
    logic          r_moving, w_moving_nxt;
    logic          r_dir, w_dir_nxt;
    logic          r_step, w_step_nxt;
    logic          r_fault, w_fault_nxt;
    logic [PW-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0] r_period, w_period_nxt;
    logic [PW-1:0] w_period_up;
    logic [5:0]    w_pat_ccw, w_pat_cw;
    logic          w_shoot, w_drive, w_drive_dir;
    cls_e          w_cls;

    assign w_pat_ccw = f_ccw_pat(r_sector);
    assign w_pat_cw  = {w_pat_ccw[4], w_pat_ccw[5], w_pat_ccw[2], w_pat_ccw[3],
                        w_pat_ccw[0], w_pat_ccw[1]};
    assign w_shoot   = (MC[5] & MC[4]) | (MC[3] & MC[2]) | (MC[1] & MC[0]);

    // Once faulted, every drive value degrades to coast.
    always_comb begin
        w_cls = ClsCoast;
        if (!r_fault) begin
            if (w_shoot)                w_cls = ClsFault;
            else if (MC == 6'b010101)   w_cls = ClsBrake;
            else if (MC == w_pat_ccw)   w_cls = ClsDriveCcw;
            else if (MC == w_pat_cw)    w_cls = ClsDriveCw;
        end
    end

    assign w_drive     = (w_cls == ClsDriveCcw) || (w_cls == ClsDriveCw);
    assign w_drive_dir = (w_cls == ClsDriveCcw);

    always_comb begin
        w_sector_nxt = r_sector;
        w_hs_nxt     = r_hs;
        w_moving_nxt = r_moving;
        w_dir_nxt    = r_dir;
        w_step_nxt   = 1'b0;
        w_fault_nxt  = r_fault | (w_cls == ClsFault);
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_period_up  = r_period + ((w_cls == ClsBrake || w_drive) ? LP_DEC4 : LP_DEC);
        if (!r_moving) begin
            if (w_drive) begin
                w_moving_nxt = 1'b1;
                w_dir_nxt    = w_drive_dir;
                w_period_nxt = LP_MAX;
                w_cnt_nxt    = '0;
            end
        end else if (r_cnt == r_period - LP_ONE) begin
            w_cnt_nxt    = '0;
            w_sector_nxt = f_next(r_sector, r_dir);
            w_hs_nxt     = f_hs(w_sector_nxt);
            w_step_nxt   = 1'b1;
            if (w_drive && (w_drive_dir == r_dir)) begin
                w_period_nxt = (r_period >= LP_MIN_ACC) ? r_period - LP_ACCEL : LP_MIN;
            end else if (w_period_up >= LP_MAX) begin
                // Final advance: rotor comes to rest on this edge.
                w_period_nxt = LP_MAX;
                w_moving_nxt = 1'b0;
            end else begin
                w_period_nxt = w_period_up;
            end
        end else begin
            w_cnt_nxt = r_cnt + LP_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sector <= 3'd1;
            r_hs     <= 3'b100;
            r_moving <= 1'b0;
            r_dir    <= 1'b1;
            r_step   <= 1'b0;
            r_fault  <= 1'b0;
            r_cnt    <= '0;
            r_period <= LP_MAX;
        end else begin
            r_sector <= w_sector_nxt;
            r_hs     <= w_hs_nxt;
            r_moving <= w_moving_nxt;
            r_dir    <= w_dir_nxt;
            r_step   <= w_step_nxt;
            r_fault  <= w_fault_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
        end
    end

    assign HS     = r_hs;
    assign sector = r_sector;
    assign moving = r_moving;
    assign dir    = r_dir;
    assign step   = r_step;
    assign fault  = r_fault;

endmodule

// File: tb/tb_hall_motor_emulator.sv
// Randomized bench for hall_motor_emulator: a cycle-level integer rotor model plus directed
// interval and Hall-sequence checks against fixed expected values.
module tb_hall_motor_emulator;
    localparam int MAXP = 64;
    localparam int MINP = 16;
    localparam int ACC  = 8;
    localparam int DEC  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] MC;
    logic [2:0] HS, sector;
    logic       moving, dir, step, fault;

    hall_motor_emulator #(
        .MAX_PERIOD(MAXP),
        .MIN_PERIOD(MINP),
        .ACCEL     (ACC),
        .DECEL     (DEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .MC    (MC),
        .HS    (HS),
        .sector(sector),
        .moving(moving),
        .dir   (dir),
        .step  (step),
        .fault (fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] ccw_pat [7] = '{6'b000000, 6'b100100, 6'b100001, 6'b001001,
                                6'b011000, 6'b010010, 6'b000110};
    logic [5:0] cw_pat  [7] = '{6'b000000, 6'b011000, 6'b010010, 6'b000110,
                                6'b100100, 6'b100001, 6'b001001};
    logic [2:0] hs_map  [7] = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    // Reference rotor: sector 1..6, cycles left until the next advance.
    int m_sector, m_period, m_left;
    bit m_moving, m_dir, m_step, m_fault;

    int         cyc = 0;
    int         t_last = 0;
    bit         prev_moving = 1'b0;
    int         ivals[$];
    int         exp_q[$];
    logic [2:0] hs_seq[$];
    logic [9:0] w_obs;

    assign w_obs = {HS, sector, moving, dir, step, fault};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [9:0] exp_vec();
        return {hs_map[m_sector], 3'(m_sector), m_moving, m_dir, m_step, m_fault};
    endfunction

    task automatic model_reset();
        m_sector = 1; m_dir = 1'b1; m_moving = 1'b0; m_step = 1'b0;
        m_fault = 1'b0; m_period = MAXP; m_left = 0;
    endtask

    task automatic model_step(input logic [5:0] mc);
        bit shoot, brake, drv, drv_ccw, set_fault;
        int np;
        shoot = (mc[5] & mc[4]) | (mc[3] & mc[2]) | (mc[1] & mc[0]);
        brake = 0; drv = 0; drv_ccw = 0; set_fault = 0;
        if (!m_fault) begin
            if (shoot)                        set_fault = 1;
            else if (mc == 6'b010101)         brake = 1;
            else if (mc == ccw_pat[m_sector]) begin drv = 1; drv_ccw = 1; end
            else if (mc == cw_pat[m_sector])  drv = 1;
        end
        m_step = 0;
        if (!m_moving) begin
            if (drv) begin
                m_moving = 1; m_dir = drv_ccw; m_period = MAXP; m_left = MAXP;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_sector = m_dir ? (m_sector % 6) + 1 : ((m_sector + 4) % 6) + 1;
                m_step = 1;
                if (drv && (drv_ccw == m_dir)) begin
                    m_period = (m_period - ACC < MINP) ? MINP : m_period - ACC;
                end else begin
                    np = m_period + ((brake || drv) ? 4 * DEC : DEC);
                    if (np >= MAXP) begin
                        m_period = MAXP; m_moving = 0;
                    end else begin
                        m_period = np;
                    end
                end
                m_left = m_period;
            end
        end
        if (set_fault) m_fault = 1;
    endtask

    // 0 CCW track, 1 CW track, 2 coast, 3 brake, 4 random safe, 5 plug, 6 random any
    function automatic logic [5:0] mc_for(input int mode);
        logic [5:0] r;
        r = 6'($urandom);
        case (mode)
            0:       return ccw_pat[m_sector];
            1:       return cw_pat[m_sector];
            2:       return 6'b000000;
            3:       return 6'b010101;
            4: begin
                if (r[5] & r[4]) r[4] = 1'b0;
                if (r[3] & r[2]) r[2] = 1'b0;
                if (r[1] & r[0]) r[0] = 1'b0;
                return r;
            end
            5:       return m_dir ? cw_pat[m_sector] : ccw_pat[m_sector];
            default: return r;
        endcase
    endfunction

    task automatic do_cycle(input logic [5:0] mc);
        MC = mc;
        @(posedge clk);
        model_step(mc);
        #1;
        cyc++;
        check("outs", 32'(w_obs), 32'(exp_vec()));
        if (moving && !prev_moving) t_last = cyc;
        if (step) begin
            ivals.push_back(cyc - t_last);
            hs_seq.push_back(HS);
            t_last = cyc;
        end
        prev_moving = moving;
    endtask

    task automatic run_steps(input int mode, input int n, input int budget);
        int k = 0;
        while (ivals.size() < n && k < budget) begin
            do_cycle(mc_for(mode));
            k++;
        end
        check("nsteps", 32'(ivals.size()), 32'(n));
    endtask

    task automatic run_stop(input int mode, input int budget);
        int k = 0;
        while (m_moving && k < budget) begin
            do_cycle(mc_for(mode));
            k++;
        end
        check("stopped", 32'(moving), 32'(0));
    endtask

    task automatic check_ivals(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < ivals.size()) ? 32'(ivals[i]) : 32'hffff_ffff, 32'(exp_q[i]));
    endtask

    task automatic clear_logs();
        ivals.delete();
        hs_seq.delete();
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", 32'(w_obs), 32'(10'b100_001_0_1_0_0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_moving = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        MC    = 6'b000000;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", 32'(w_obs), 32'(10'b100_001_0_1_0_0));
        rst_n = 1'b1;

        repeat (200) do_cycle(6'b000000);

        // CCW acceleration from standstill.
        clear_logs();
        run_steps(0, 8, 1000);
        exp_q = '{64, 56, 48, 40, 32, 24, 16, 16};
        check_ivals("ccw_ival");
        exp_q = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};
        for (int i = 0; i < 6; i++)
            check("ccw_hs", (i < hs_seq.size()) ? 32'(hs_seq[i]) : 32'hffff_ffff,
                  32'(exp_q[i]));
        check("ccw_dir", 32'(dir), 32'(1));

        // Coast down from the minimum period.
        clear_logs();
        run_stop(2, 2000);
        for (int k = 0; k < 12; k++) exp_q.push_back(16 + 4 * k);
        check_ivals("coast_ival");
        check("coast_n", 32'(ivals.size()), 32'(12));

        // Re-accelerate, then brake.
        clear_logs();
        run_steps(0, 8, 1000);
        clear_logs();
        run_stop(3, 1000);
        exp_q = '{16, 32, 48};
        check_ivals("brake_ival");
        check("brake_n", 32'(ivals.size()), 32'(3));
        repeat (40) do_cycle(6'b010101);

        // CW from reset, then plugging.
        pulse_reset();
        clear_logs();
        run_steps(1, 8, 1000);
        check("cw_dir", 32'(dir), 32'(0));
        exp_q = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
        for (int i = 0; i < 6; i++)
            check("cw_hs", (i < hs_seq.size()) ? 32'(hs_seq[i]) : 32'hffff_ffff,
                  32'(exp_q[i]));
        clear_logs();
        run_stop(5, 1000);
        exp_q = '{16, 32, 48};
        check_ivals("plug_ival");

        for (int s = 0; s < 25; s++) begin
            int mode = $urandom_range(0, 5);
            int len  = $urandom_range(20, 250);
            repeat (len) do_cycle(mc_for(mode));
        end

        // Shoot-through while running at speed.
        run_stop(2, 2000);
        clear_logs();
        run_steps(0, 8, 1000);
        do_cycle(6'b110000);
        check("fault_set", 32'(fault), 32'(1));
        clear_logs();
        run_steps(0, 3, 1000);
        exp_q = '{16, 20, 24};
        check_ivals("fault_ival");
        check("fault_hold", 32'(fault), 32'(1));
        check("fault_moving", 32'(moving), 32'(1));
        pulse_reset();

        for (int s = 0; s < 10; s++) begin
            int mode = $urandom_range(0, 6);
            int len  = $urandom_range(20, 200);
            repeat (len) do_cycle(mc_for(mode));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
